lsu_mem_master: RTL and testbench

//   Load/store initiator for the data memory. Accepts one byte/half/word load or store
//   per handshake from the datapath, drives the active-low cs/wr, byte-mask, word-address

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_mem_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
// byte_enables() is used both for the request-time range check and by the datapath.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic WR_WRITE  = 1'b0;
    localparam logic WR_READ   = 1'b1;

    // Byte enables across two consecutive words: bits [3:0] first word, [7:4] second.
    function automatic logic [7:0] byte_enables(input size_e size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'b0000_0001;
            SZ_H:    base = 8'b0000_0011;
            SZ_W:    base = 8'b0000_1111;
            default: base = 8'b0000_0000;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for stores and extraction/extension for loads, spanning up to two words.
// Purely combinational; the caller supplies the captured request context.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  be8,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata_ext
);

    logic [4:0]  sh;
    logic [63:0] wide_w;
    logic [31:0] shifted_r;

    assign sh       = {off, 3'b000};
    assign be8      = byte_enables(size, off);
    assign wide_w   = {32'h0, wdata} << sh;
    assign wdata_lo = wide_w[31:0];
    assign wdata_hi = wide_w[63:32];

    // Loads that fit in one word never look at hi, so a stale hi is harmless.
    assign shifted_r = 32'({hi, lo} >> sh);

    always_comb begin
        rdata_ext = 32'h0;
        case (size)
            SZ_B: rdata_ext = is_unsigned ? {24'h0, shifted_r[7:0]}
                                          : {{24{shifted_r[7]}}, shifted_r[7:0]};
            SZ_H: rdata_ext = is_unsigned ? {16'h0, shifted_r[15:0]}
                                          : {{16{shifted_r[15]}}, shifted_r[15:0]};
            SZ_W: rdata_ext = shifted_r;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte/half/word access per request, split into two word
// cycles when it straddles a word boundary. Memory port is decoded from registered state.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a posedge with req_valid && req_ready; req_ready is
    // high only in IDLE, so one request is in flight; rsp_valid is a one-cycle pulse, no back-pressure.

    localparam logic [30:0] DEPTH_W = 31'(MEM_DEPTH);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    size_e       size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;

    size_e       req_size_e;
    logic [7:0]  req_be8;
    logic [30:0] req_word;
    logic        req_err;

    logic [7:0]  be8;
    logic [31:0] wdata_lo;
    logic [31:0] wdata_hi;
    logic [31:0] ld_data;
    logic        in_acc;

    assign req_size_e = size_e'(req_size);
    assign req_be8    = byte_enables(req_size_e, req_addr[1:0]);
    assign req_word   = {1'b0, req_addr[31:2]};
    assign req_err    = (req_size_e == SZ_BAD)
                     || (req_word >= DEPTH_W)
                     || ((req_be8[7:4] != 4'h0) && ((req_word + 31'd1) >= DEPTH_W));

    lsu_align u_align (
        .size        (size_q),
        .off         (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .lo          (lo_q),
        .hi          (hi_q),
        .be8         (be8),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .rdata_ext   (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    size_d     = req_size_e;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    lo_d       = 32'h0;
                    hi_d       = 32'h0;
                    err_d      = req_err;
                    state_d    = req_err ? RESP : ACC0;
                end
            end
            ACC0: begin
                if (!store_q) lo_d = mem_rdata;
                state_d = (be8[7:4] != 4'h0) ? ACC1 : RESP;
            end
            ACC1: begin
                if (!store_q) hi_d = mem_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 32'h0;
            hi_q       <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            err_q      <= err_d;
        end
    end

    assign in_acc    = (state_q == ACC0) || (state_q == ACC1);
    assign dbg_state = state_q;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && !store_q && !err_q) ? ld_data : 32'h0;

    assign mem_cs = in_acc ? CS_ACTIVE : ~CS_ACTIVE;
    assign mem_wr = (in_acc && store_q) ? WR_WRITE : WR_READ;

    always_comb begin
        mem_addr  = 32'h0;
        mem_mask  = 4'h0;
        mem_wdata = 32'h0;
        case (state_q)
            ACC0: begin
                mem_addr  = {2'b00, addr_q[31:2]};
                mem_mask  = store_q ? be8[3:0] : 4'h0;
                mem_wdata = wdata_lo;
            end
            ACC1: begin
                mem_addr  = {2'b00, addr_q[31:2] + 30'd1};
                mem_mask  = store_q ? be8[7:4] : 4'h0;
                mem_wdata = wdata_hi;
            end
            default: begin
                mem_addr  = 32'h0;
                mem_mask  = 4'h0;
                mem_wdata = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural word memory, request driver, and two scoreboards
// (responses and memory-port cycles) checked by independent negedge monitors.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    localparam int unsigned MEM_DEPTH = 1024;
    localparam int RW = 49;  // {err, rdata, expected response cycle[15:0]}
    localparam int AW = 69;  // {wr, mask, addr, wdata}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs;
    logic        mem_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0]   mem [0:MEM_DEPTH-1];
    logic [RW-1:0] exp_q[$];
    logic [AW-1:0] acc_q[$];
    int unsigned   cyc = 0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    lsu_mem_master #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_cs       (mem_cs),
        .mem_wr       (mem_wr),
        .mem_mask     (mem_mask),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // Clock / reset-free cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, byte-masked write on the negedge
    assign mem_rdata = (mem_addr < MEM_DEPTH) ? mem[mem_addr[9:0]] : 32'h0;

    always @(negedge clk) begin
        if (mem_cs === 1'b0 && mem_wr === 1'b0 && mem_addr < MEM_DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Response monitor
    always @(negedge clk) begin : rsp_mon
        logic [RW-1:0] e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {63'h0, rsp_valid}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", {63'h0, rsp_err}, {63'h0, e[48]});
                check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e[47:16]});
                check("rsp_cycle", {48'h0, cyc[15:0]}, {48'h0, e[15:0]});
            end
        end
    end

    // Memory-port monitor
    always @(negedge clk) begin : acc_mon
        logic [AW-1:0] a;
        if (mem_cs === 1'b0) begin
            if (acc_q.size() == 0) begin
                check("acc_unexpected", {63'h0, mem_cs}, 64'h1);
            end else begin
                a = acc_q.pop_front();
                check("acc_wr", {63'h0, mem_wr}, {63'h0, a[68]});
                check("acc_mask", {60'h0, mem_mask}, {60'h0, a[67:64]});
                check("acc_addr", {32'h0, mem_addr}, {32'h0, a[63:32]});
                check("acc_wdata", {32'h0, mem_wdata}, {32'h0, a[31:0]});
            end
        end
    end

    task automatic exp_acc(input logic wr, input logic [3:0] mask, input logic [31:0] addr,
                           input logic [31:0] wd);
        acc_q.push_back({wr, mask, addr, wd});
    endtask

    // Called at a negedge; returns at the negedge where req_ready is back high.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                          input logic keep);
        int waited;
        int busy;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("accept_wait", {63'h0, req_ready}, 64'h1);
        exp_q.push_back({exp_err, exp_rdata, 16'(cyc + 32'(lat))});
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        busy = 0;
        while (req_ready !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy), 64'(lat));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_state", {62'h0, dbg_state}, {62'h0, IDLE});
        check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("reset_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
        check("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
        check("reset_mem_cs", {63'h0, mem_cs}, 64'h1);
        check("reset_mem_wr", {63'h0, mem_wr}, 64'h1);
        check("reset_mem_mask", {60'h0, mem_mask}, 64'h0);
        check("reset_mem_addr", {32'h0, mem_addr}, 64'h0);
        check("reset_mem_wdata", {32'h0, mem_wdata}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Aligned word store/load
        exp_acc(1'b0, 4'b1111, 32'd4, 32'hDEADBEEF);
        do_req(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

        // Byte store in the top lane, signed/unsigned byte and half loads (word4 = 0x80ADBEEF)
        exp_acc(1'b0, 4'b1000, 32'd4, 32'h80000000);
        do_req(1'b1, SZ_B, 1'b0, 32'h13, 32'h00000080, 32'h0, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 2, 1'b0);

        // Split word store: word3 = 0x33440000, word4 = 0x80AD1122
        exp_acc(1'b0, 4'b1100, 32'd3, 32'h33440000);
        exp_acc(1'b0, 4'b0011, 32'd4, 32'h00001122);
        do_req(1'b1, SZ_W, 1'b0, 32'h0E, 32'h11223344, 32'h0, 1'b0, 3, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd3, 32'h0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'h0E, 32'h0, 32'h11223344, 1'b0, 3, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd3, 32'h0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_H, 1'b1, 32'h0F, 32'h0, 32'h00002233, 1'b0, 3, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd3, 32'h0);
        do_req(1'b0, SZ_B, 1'b0, 32'h0E, 32'h0, 32'h00000044, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd4, 32'h0);
        do_req(1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'h80AD1122, 1'b0, 2, 1'b0);

        // Errors: no memory cycle, response one cycle after accept
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        do_req(1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        do_req(1'b1, SZ_B, 1'b0, 32'h1000, 32'h55, 32'h0, 1'b1, 1, 1'b0);
        do_req(1'b0, SZ_W, 1'b0, 32'hFFE, 32'h0, 32'h0, 1'b1, 1, 1'b0);

        // Last word is still in range
        exp_acc(1'b0, 4'b1100, 32'd1023, 32'hA5A50000);
        do_req(1'b1, SZ_H, 1'b0, 32'hFFE, 32'h0000A5A5, 32'h0, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd1023, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, 32'hA5A50000, 1'b0, 2, 1'b0);

        // Reset after the first half of a split store: word8 written, word9 untouched
        exp_acc(1'b0, 4'b1100, 32'd8, 32'hCCDD0000);
        req_store    = 1'b1;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_addr     = 32'h22;
        req_wdata    = 32'hAABBCCDD;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", {62'h0, dbg_state}, {62'h0, IDLE});
        check("abort_mem_cs", {63'h0, mem_cs}, 64'h1);
        check("abort_mem_wr", {63'h0, mem_wr}, 64'h1);
        check("abort_mem_mask", {60'h0, mem_mask}, 64'h0);
        check("abort_mem_addr", {32'h0, mem_addr}, 64'h0);
        check("abort_mem_wdata", {32'h0, mem_wdata}, 64'h0);
        check("abort_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        exp_acc(1'b1, 4'b0000, 32'd8, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCCDD0000, 1'b0, 2, 1'b0);
        exp_acc(1'b1, 4'b0000, 32'd9, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h00000000, 1'b0, 2, 1'b0);

        // req_valid held high across back-to-back requests
        exp_acc(1'b0, 4'b0011, 32'd16, 32'h0000BEEF);
        do_req(1'b1, SZ_H, 1'b0, 32'h40, 32'h0000BEEF, 32'h0, 1'b0, 2, 1'b1);
        exp_acc(1'b1, 4'b0000, 32'd16, 32'h0);
        do_req(1'b0, SZ_H, 1'b1, 32'h40, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1);
        exp_acc(1'b1, 4'b0000, 32'd16, 32'h0);
        do_req(1'b0, SZ_H, 1'b0, 32'h40, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b0);

        repeat (5) @(negedge clk);
        check("rsp_queue_drained", 64'(exp_q.size()), 64'h0);
        check("acc_queue_drained", 64'(acc_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
